core_dispatcher: RTL and testbench

Upstream launch and completion controller for the array of matrix-multiplier cores. It takes a single host "go" pulse and a core-enable mask, and drives each enabled core's start input. It handshakes on each core's busy output, waits for every launched core to finish, and reports done, error and a total cycle count. It is the only driver of the cores' start inputs.

---
 rtl/core_dispatch_pkg.sv | 18 +
 rtl/core_slot_tracker.sv | 54 +++++
 rtl/core_dispatcher.sv | 144 ++++++++++++++
 tb/tb_core_dispatcher.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/core_dispatch_pkg.sv
// Shared types for the core launch/completion dispatcher.
package core_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int ACK_TIMEOUT_DEFAULT = 16;

    // The timeout counter only needs to hold 0..ack_timeout-1.
    function automatic int tmo_width(input int ack_timeout);
        return (ack_timeout < 2) ? 1 : $clog2(ack_timeout);
    endfunction

endpackage

// File: rtl/core_slot_tracker.sv
// Per-core launch bookkeeping: start request, acknowledge, finish and timeout error.
module core_slot_tracker (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_act,
    input  logic i_busy,
    input  logic i_launch_en,
    input  logic i_timeout_hit,
    output logic o_start,
    output logic o_ack,
    output logic o_fin,
    output logic o_err
);

    logic r_start;
    logic r_ack;
    logic r_fin;
    logic r_err;

    // Start is armed on the accepting go edge so it is high from the first
    // LAUNCH cycle; it drops on acknowledge or on the timeout edge. An ack
    // on the timeout edge wins over the error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start <= 1'b0;
            r_ack   <= 1'b0;
            r_fin   <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_clear) begin
            r_start <= i_act;
            r_ack   <= 1'b0;
            r_fin   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (i_launch_en && r_start && i_busy) begin
                r_ack   <= 1'b1;
                r_start <= 1'b0;
            end else if (i_launch_en && r_start && i_timeout_hit) begin
                r_err   <= 1'b1;
                r_start <= 1'b0;
            end
            if (r_ack && !i_busy) begin
                r_fin <= 1'b1;
            end
        end
    end

    assign o_start = r_start;
    assign o_ack   = r_ack;
    assign o_fin   = r_fin;
    assign o_err   = r_err;

endmodule

// File: rtl/core_dispatcher.sv
// Launch and completion controller for the matrix-multiplier core array.
//
// state  | meaning
// IDLE   | waiting for i_go; error flags and cycle count hold
// LAUNCH | start driven to un-acked cores; timeout counter running
// RUN    | waiting for every acked core to drop busy
// DONE   | one-cycle o_done pulse, then back to IDLE
module core_dispatcher
    import core_dispatch_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int CNT_W       = 32,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_go,
    input  logic [NUM_CORES-1:0] i_core_mask,
    input  logic [NUM_CORES-1:0] i_core_busy,
    output logic [NUM_CORES-1:0] o_core_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [NUM_CORES-1:0] o_err_mask,
    output logic [CNT_W-1:0]     o_cycles
);

    localparam int               TMO_W    = tmo_width(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t               r_state;
    logic [NUM_CORES-1:0] r_act;
    logic [TMO_W-1:0]     r_tmo;
    logic [CNT_W-1:0]     r_cycles;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_clear;
    logic                 w_launch;
    logic                 w_tmo_hit;
    logic [NUM_CORES-1:0] w_act_in;
    logic [NUM_CORES-1:0] w_start;
    logic [NUM_CORES-1:0] w_ack;
    logic [NUM_CORES-1:0] w_fin;
    logic [NUM_CORES-1:0] w_err;
    logic [NUM_CORES-1:0] w_ack_next;
    logic                 w_all_acked;
    logic                 w_any_ack;
    logic                 w_pending;
    logic [CNT_W-1:0]     w_cycles_inc;

    assign w_clear   = (r_state == ST_IDLE) && i_go;
    assign w_launch  = (r_state == ST_LAUNCH);
    assign w_tmo_hit = w_launch && (r_tmo == TMO_LAST);
    // While idle the slots see the incoming mask so start can be armed on the go edge.
    assign w_act_in  = (r_state == ST_IDLE) ? i_core_mask : r_act;

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_slot
        core_slot_tracker u_slot (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_clear       (w_clear),
            .i_act         (w_act_in[k]),
            .i_busy        (i_core_busy[k]),
            .i_launch_en   (w_launch),
            .i_timeout_hit (w_tmo_hit),
            .o_start       (w_start[k]),
            .o_ack         (w_ack[k]),
            .o_fin         (w_fin[k]),
            .o_err         (w_err[k])
        );
    end

    // Acks landing on this edge count toward leaving LAUNCH.
    assign w_ack_next   = w_ack | (w_start & i_core_busy);
    assign w_all_acked  = ((r_act & ~w_ack_next) == '0);
    assign w_any_ack    = |w_ack_next;
    assign w_pending    = |(w_ack & ~w_fin);
    assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + 1'b1;

    // Sequencer with registered busy/done and run-cycle counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_act    <= '0;
            r_tmo    <= '0;
            r_cycles <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_go) begin
                        r_cycles <= '0;
                        r_tmo    <= '0;
                        if (|i_core_mask) begin
                            r_act   <= i_core_mask;
                            r_busy  <= 1'b1;
                            r_state <= ST_LAUNCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_tmo    <= r_tmo + 1'b1;
                    r_cycles <= w_cycles_inc;
                    if (w_tmo_hit) begin
                        if (w_any_ack) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else if (w_all_acked) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_cycles <= w_cycles_inc;
                    if (!w_pending) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_core_start = w_start;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err_mask   = w_err;
    assign o_error      = |w_err;
    assign o_cycles     = r_cycles;

endmodule

// File: tb/tb_core_dispatcher.sv
// Directed bench for core_dispatcher with a behavioural core model and a result scoreboard.
module tb_core_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [3:0]  mask;
    logic [3:0]  busy_in;
    logic [3:0]  o_core_start;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [3:0]  o_err_mask;
    logic [31:0] o_cycles;

    core_dispatcher #(.NUM_CORES(4), .CNT_W(32), .ACK_TIMEOUT(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_go         (go),
        .i_core_mask  (mask),
        .i_core_busy  (busy_in),
        .o_core_start (o_core_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_err_mask   (o_err_mask),
        .o_cycles     (o_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  err_mask;
        logic        error;
        logic [31:0] cycles;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Core model: core k holds busy high during run cycles [rise[k], fall[k]),
    // where cycle 0 is the first cycle after the go edge.
    int         rise[4];
    int         fall[4];
    int         exp_start[4];
    int         gb_t;
    logic [3:0] gb_mask;
    int         rst_t;
    int         limit;

    int start_cnt[4];
    int busy_cnt;
    int done_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    endtask

    task automatic defaults();
        rise    = '{1000, 1000, 1000, 1000};
        fall    = '{0, 0, 0, 0};
        gb_t    = -1;
        gb_mask = 4'b0000;
        rst_t   = -1;
        limit   = 60;
    endtask

    task automatic run(input string tag, input logic [3:0] m, input bit expect_done,
                       input logic [3:0] e_mask, input logic e_err, input int e_cycles,
                       input int e_busy);
        int   t;
        int   done_t;
        exp_t e;
        for (int k = 0; k < 4; k++) start_cnt[k] = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_t   = -1;
        @(negedge clk);
        go   = 1'b1;
        mask = m;
        if (expect_done) begin
            e.err_mask = e_mask;
            e.error    = e_err;
            e.cycles   = 32'(e_cycles);
            sb.push_back(e);
        end
        @(negedge clk);
        go = 1'b0;
        t  = 0;
        while (t < limit && !(done_t >= 0 && t > done_t + 3)) begin
            for (int k = 0; k < 4; k++) if (o_core_start[k]) start_cnt[k]++;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
                chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, "_err_mask"}, 32'(o_err_mask), 32'(e.err_mask));
                    chk({tag, "_error"},    32'(o_error),    32'(e.error));
                    chk({tag, "_cycles"},   o_cycles,        e.cycles);
                end
            end
            if (rst_t >= 0 && t == rst_t + 1) begin
                chk({tag, "_rst_start"},    32'(o_core_start), 32'd0);
                chk({tag, "_rst_busy"},     32'(o_busy),       32'd0);
                chk({tag, "_rst_done"},     32'(o_done),       32'd0);
                chk({tag, "_rst_error"},    32'(o_error),      32'd0);
                chk({tag, "_rst_err_mask"}, 32'(o_err_mask),   32'd0);
                chk({tag, "_rst_cycles"},   o_cycles,          32'd0);
            end
            for (int k = 0; k < 4; k++) busy_in[k] = (t >= rise[k]) && (t < fall[k]);
            go   = (t == gb_t);
            mask = (t == gb_t) ? gb_mask : m;
            rst  = (t == rst_t);
            @(negedge clk);
            t++;
        end
        rst     = 1'b0;
        go      = 1'b0;
        busy_in = 4'b0000;
        chk({tag, "_done_count"}, 32'(done_cnt), expect_done ? 32'd1 : 32'd0);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e_busy));
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_start%0d_cycles", tag, k), 32'(start_cnt[k]), 32'(exp_start[k]));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        go      = 1'b0;
        mask    = 4'b0000;
        busy_in = 4'b0000;
        defaults();
        repeat (3) @(negedge clk);
        chk("reset_start",    32'(o_core_start), 32'd0);
        chk("reset_busy",     32'(o_busy),       32'd0);
        chk("reset_done",     32'(o_done),       32'd0);
        chk("reset_error",    32'(o_error),      32'd0);
        chk("reset_err_mask", 32'(o_err_mask),   32'd0);
        chk("reset_cycles",   o_cycles,          32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All four cores: ack at end of cycle 1 (start 2 cycles), busy low from
        // cycle 12, fin seen in cycle 13, DONE after 14 LAUNCH+RUN cycles.
        defaults();
        rise = '{1, 1, 1, 1};
        fall = '{12, 12, 12, 12};
        exp_start = '{2, 2, 2, 2};
        run("basic", 4'b1111, 1'b1, 4'b0000, 1'b0, 14, 14);

        // Cores 0 and 2 only; core3 raises a stray busy that must be ignored.
        // Core2 busy low from cycle 28 -> 30 cycles.
        defaults();
        rise = '{1, 1000, 1, 3};
        fall = '{5, 0, 28, 7};
        exp_start = '{2, 0, 2, 0};
        run("stagger", 4'b0101, 1'b1, 4'b0000, 1'b0, 30, 30);

        // Core1 never acks: start high 16 cycles, error on the timeout edge,
        // RUN for one cycle (core0 already finished), late busy on core1 ignored.
        defaults();
        rise = '{1, 16, 1000, 1000};
        fall = '{6, 20, 0, 0};
        exp_start = '{2, 16, 0, 0};
        run("timeout", 4'b0011, 1'b1, 4'b0010, 1'b1, 17, 17);

        // No acknowledge at all: DONE straight from LAUNCH after 16 cycles.
        defaults();
        exp_start = '{16, 0, 0, 0};
        run("noack", 4'b0001, 1'b1, 4'b0001, 1'b1, 16, 16);

        // Zero mask: DONE right after go, clears the previous error state.
        defaults();
        exp_start = '{0, 0, 0, 0};
        run("zeromask", 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0);

        // Reset asserted during RUN (cycle 5): no done, outputs cleared.
        defaults();
        rise = '{1, 1, 1, 1};
        fall = '{12, 12, 12, 12};
        rst_t = 5;
        limit = 20;
        exp_start = '{2, 2, 2, 2};
        run("midreset", 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 6);

        // Clean run after the reset.
        defaults();
        rise = '{1, 1, 1, 1};
        fall = '{12, 12, 12, 12};
        exp_start = '{2, 2, 2, 2};
        run("after_reset", 4'b1111, 1'b1, 4'b0000, 1'b0, 14, 14);

        // Go with a different mask during RUN is ignored; other cores go busy too.
        defaults();
        rise = '{1, 5, 5, 5};
        fall = '{10, 8, 8, 8};
        gb_t = 4;
        gb_mask = 4'b1110;
        exp_start = '{2, 0, 0, 0};
        run("go_busy", 4'b0001, 1'b1, 4'b0000, 1'b0, 12, 12);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
